rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/arm_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/rf_wb_arbiter.sv | 101 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared constants and types for the register-file writeback path.
package arm_pkg;

    localparam int NUM_REQ  = 3;
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_LINK = 2;

    localparam logic [3:0] PC_ADDR = 4'hF;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the pointer.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: round-robin grant onto the single register-file write
// port, destination-register scoreboard for hazard detection, and flush FSM.
module rf_wb_arbiter #(
    parameter int NUM_REQ = arm_pkg::NUM_REQ,
    parameter int DATA_W  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             wb_valid,
    output logic [NUM_REQ-1:0]             wb_ready,
    input  logic [NUM_REQ-1:0][3:0]        wb_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] wb_data,
    input  logic                           claim_valid,
    input  logic [3:0]                     claim_addr,
    input  logic [3:0]                     ARn,
    input  logic [3:0]                     ARs,
    input  logic [3:0]                     ARm,
    output logic                           hazard,
    output logic                           wen_ARd,
    output logic [3:0]                     ARd,
    output logic [DATA_W-1:0]              Rd_data,
    output logic                           pc_redirect,
    input  logic                           flush,
    output logic                           flush_busy,
    output logic [7:0]                     wr_count
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arm_pkg::wb_state_t state;
    logic [PW-1:0]      last_grant;
    logic [15:0]        busy;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               xfer;
    logic [3:0]         sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req     (wb_valid),
        .ptr     (last_grant),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The edge that raises flush is still in RUN, so its transfer completes.
    assign wb_ready = (state == arm_pkg::ST_RUN) ? gnt : '0;
    assign xfer     = |(wb_valid & wb_ready);
    assign sel_addr = wb_addr[gnt_idx];
    assign sel_data = wb_data[gnt_idx];
    assign hazard   = busy[ARn] | busy[ARs] | busy[ARm];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= arm_pkg::ST_RUN;
            flush_busy <= 1'b0;
            busy       <= '0;
        end else begin
            case (state)
                arm_pkg::ST_RUN: begin
                    state      <= flush ? arm_pkg::ST_FLUSH : arm_pkg::ST_RUN;
                    flush_busy <= flush;
                    // Claim is applied after the clear so a same-edge pair stays busy.
                    begin
                        logic [15:0] busy_n;
                        busy_n = busy;
                        if (xfer)        busy_n[sel_addr]   = 1'b0;
                        if (claim_valid) busy_n[claim_addr] = 1'b1;
                        busy <= busy_n;
                    end
                end
                default: begin
                    state      <= flush ? arm_pkg::ST_FLUSH : arm_pkg::ST_RUN;
                    flush_busy <= flush;
                    busy       <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= PW'(NUM_REQ - 1);
            wen_ARd     <= 1'b0;
            ARd         <= '0;
            Rd_data     <= '0;
            pc_redirect <= 1'b0;
            wr_count    <= '0;
        end else begin
            wen_ARd     <= xfer;
            pc_redirect <= xfer && (sel_addr == arm_pkg::PC_ADDR);
            if (xfer) begin
                last_grant <= gnt_idx;
                ARd        <= sel_addr;
                Rd_data    <= sel_data;
                wr_count   <= wr_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       wb_valid;
    logic [2:0]       wb_ready;
    logic [2:0][3:0]  wb_addr;
    logic [2:0][31:0] wb_data;
    logic             claim_valid;
    logic [3:0]       claim_addr;
    logic [3:0]       ARn, ARs, ARm;
    logic             hazard;
    logic             wen_ARd;
    logic [3:0]       ARd;
    logic [31:0]      Rd_data;
    logic             pc_redirect;
    logic             flush;
    logic             flush_busy;
    logic [7:0]       wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_arbiter #(.NUM_REQ(3), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .ARn(ARn), .ARs(ARs), .ARm(ARm),
        .hazard(hazard),
        .wen_ARd(wen_ARd), .ARd(ARd), .Rd_data(Rd_data),
        .pc_redirect(pc_redirect),
        .flush(flush), .flush_busy(flush_busy),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = '0; claim_valid = 1'b0; claim_addr = '0;
        ARn = '0; ARs = '0; ARm = '0; flush = 1'b0;
        wb_addr[0] = 4'd1; wb_addr[1] = 4'd2; wb_addr[2] = 4'd4;
        wb_data[0] = 32'h11; wb_data[1] = 32'h22; wb_data[2] = 32'h44;
        #2;
        chk("rst_wen",   64'(wen_ARd),     64'd0);
        chk("rst_ard",   64'(ARd),         64'd0);
        chk("rst_data",  64'(Rd_data),     64'd0);
        chk("rst_pc",    64'(pc_redirect), 64'd0);
        chk("rst_cnt",   64'(wr_count),    64'd0);
        chk("rst_fbusy", 64'(flush_busy),  64'd0);
        chk("rst_haz",   64'(hazard),      64'd0);
        step();
        rst = 1'b0;

        // Round-robin with all requesters valid: 0,1,2,0,1,2
        wb_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_ready", 64'(wb_ready), 64'(3'b001 << (i % 3)));
            step();
            chk("rr_wen", 64'(wen_ARd), 64'd1);
            chk("rr_ard", 64'(ARd), (i % 3 == 0) ? 64'd1 : (i % 3 == 1) ? 64'd2 : 64'd4);
        end
        chk("rr_cnt", 64'(wr_count), 64'd6);
        wb_valid = '0;
        step();
        chk("idle_wen", 64'(wen_ARd), 64'd0);
        chk("idle_ard_hold", 64'(ARd), 64'd4);
        chk("idle_data_hold", 64'(Rd_data), 64'h44);

        // Claim r5, then ALU writes r5
        claim_valid = 1'b1; claim_addr = 4'd5;
        step();
        claim_valid = 1'b0; ARn = 4'd5;
        #1;
        chk("claim_haz", 64'(hazard), 64'd1);
        wb_addr[0] = 4'd5; wb_data[0] = 32'h0000_00AA; wb_valid = 3'b001;
        #1;
        chk("alu_ready", 64'(wb_ready), 64'(3'b001));
        step();
        wb_valid = '0;
        chk("alu_wen", 64'(wen_ARd), 64'd1);
        chk("alu_ard", 64'(ARd), 64'd5);
        chk("alu_data", 64'(Rd_data), 64'hAA);
        chk("alu_haz_clr", 64'(hazard), 64'd0);
        chk("alu_cnt", 64'(wr_count), 64'd7);

        // Same-edge claim and link write to r3
        ARn = 4'd0;
        wb_addr[2] = 4'd3; wb_data[2] = 32'h33; wb_valid = 3'b100;
        claim_valid = 1'b1; claim_addr = 4'd3;
        #1;
        chk("link_ready", 64'(wb_ready), 64'(3'b100));
        step();
        wb_valid = '0; claim_valid = 1'b0; ARm = 4'd3;
        #1;
        chk("same_edge_haz", 64'(hazard), 64'd1);
        chk("link_ard", 64'(ARd), 64'd3);

        // Load writes r15 -> pc_redirect pulse
        wb_addr[1] = 4'hF; wb_data[1] = 32'h20; wb_valid = 3'b010;
        #1;
        chk("load_ready", 64'(wb_ready), 64'(3'b010));
        step();
        wb_valid = '0;
        chk("pc_pulse", 64'(pc_redirect), 64'd1);
        chk("pc_ard", 64'(ARd), 64'hF);
        chk("pc_data", 64'(Rd_data), 64'h20);
        step();
        chk("pc_pulse_end", 64'(pc_redirect), 64'd0);
        chk("pc_cnt", 64'(wr_count), 64'd9);

        // Flush: the rising edge still transfers (link, search starts at 2)
        wb_addr[2] = 4'd7; wb_data[2] = 32'h77; wb_valid = 3'b111; flush = 1'b1;
        #1;
        chk("fl_edge_ready", 64'(wb_ready), 64'(3'b100));
        step();
        chk("fl_edge_wen", 64'(wen_ARd), 64'd1);
        chk("fl_edge_data", 64'(Rd_data), 64'h77);
        chk("fl_busy", 64'(flush_busy), 64'd1);
        chk("fl_ready", 64'(wb_ready), 64'd0);
        claim_valid = 1'b1; claim_addr = 4'd9; ARs = 4'd9;
        step();
        step();
        chk("fl_ready2", 64'(wb_ready), 64'd0);
        chk("fl_wen", 64'(wen_ARd), 64'd0);
        chk("fl_haz", 64'(hazard), 64'd0);
        chk("fl_busy2", 64'(flush_busy), 64'd1);
        chk("fl_cnt", 64'(wr_count), 64'd10);
        flush = 1'b0; claim_valid = 1'b0;
        step();
        chk("fl_exit", 64'(flush_busy), 64'd0);
        chk("fl_exit_haz", 64'(hazard), 64'd0);

        // 246 more transfers bring the count to 256 -> wraps to 0
        for (int i = 0; i < 246; i++) begin
            step();
            if (i == 244) chk("cnt_255", 64'(wr_count), 64'd255);
        end
        chk("cnt_wrap", 64'(wr_count), 64'd0);
        chk("wrap_wen", 64'(wen_ARd), 64'd1);

        // Asynchronous reset mid-cycle with load valid
        wb_valid = 3'b010;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wen", 64'(wen_ARd), 64'd0);
        chk("arst_ard", 64'(ARd), 64'd0);
        chk("arst_data", 64'(Rd_data), 64'd0);
        chk("arst_cnt", 64'(wr_count), 64'd0);
        step();
        chk("arst_drop", 64'(wen_ARd), 64'd0);
        rst = 1'b0;
        wb_addr[0] = 4'd1; wb_valid = 3'b011;
        #1;
        chk("arst_first_ready", 64'(wb_ready), 64'(3'b001));
        step();
        chk("arst_first_ard", 64'(ARd), 64'd1);
        chk("arst_first_cnt", 64'(wr_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
